// File: rtl/msg_packer.sv
// msg_packer: round-robin arbiter and framer for up to N_CH slave channels.
// Picks the next channel holding a non-empty message, reads its FIFO one byte
// at a time and sends the message as a framed packet on a byte stream:
//   SYNC, channel address, length, payload bytes, XOR checksum.
// The checksum covers the address, length and payload bytes, not SYNC.
//
// Ports:
//   sys_clk        clock for all logic
//   n_rst          asynchronous, active-low reset
//   have_msg_bus   bit i: channel i has a message pending
//   len_bus        byte i: channel i available byte count
//   slave_data_bus byte i: channel i FIFO output, valid the cycle after rdreq
//   rdreq_bus      one-cycle read strobe per channel
//   tx_data        stream byte
//   tx_valid       tx_data is valid
//   tx_ready       sink accepts (transfer = tx_valid & tx_ready)
//   busy           high from packet selection until the checksum is accepted
module msg_packer #(
  parameter int         N_CH = 5,
  parameter logic [7:0] SYNC = 8'h55
) (
  input  logic                sys_clk,
  input  logic                n_rst,
  input  logic [N_CH-1:0]     have_msg_bus,
  input  logic [8*N_CH-1:0]   len_bus,
  input  logic [8*N_CH-1:0]   slave_data_bus,
  output logic [N_CH-1:0]     rdreq_bus,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_ADDR, ST_LEN, ST_FETCH, ST_CAPTURE, ST_SEND, ST_CSUM
  } state_t;

  state_t        state;
  logic [CW-1:0] ch;
  logic [CW-1:0] rr_ptr;
  logic [7:0]    rem;
  logic [7:0]    checksum;

  logic          hit;
  logic [CW-1:0] hit_ch;
  logic [7:0]    hit_len;
  logic [7:0]    ch_byte;
  logic [7:0]    slave_byte;
  logic          xfer;

  assign xfer       = tx_valid & tx_ready;
  assign ch_byte    = 8'(ch);
  assign hit_len    = len_bus[8*hit_ch +: 8];
  assign slave_byte = slave_data_bus[8*ch +: 8];

  // Successor of a channel index, wrapping at N_CH.
  function automatic logic [CW-1:0] rr_next(input logic [CW-1:0] c);
    if (c == CW'(N_CH - 1)) rr_next = '0;
    else                    rr_next = c + 1'b1;
  endfunction

  // One-hot read strobe for a channel.
  function automatic logic [N_CH-1:0] strobe(input logic [CW-1:0] c);
    strobe = {{(N_CH-1){1'b0}}, 1'b1} << c;
  endfunction

  // Round-robin search starting at rr_ptr. Scanning from the far end down
  // lets the candidate closest to rr_ptr overwrite the others. Channels that
  // flag a message but report zero length are not eligible.
  always_comb begin
    hit    = 1'b0;
    hit_ch = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr) + k) % N_CH;
      if (have_msg_bus[idx] && (len_bus[8*idx +: 8] != 8'd0)) begin
        hit    = 1'b1;
        hit_ch = CW'(idx);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= ST_IDLE;
      ch        <= '0;
      rr_ptr    <= '0;
      rem       <= '0;
      checksum  <= '0;
      rdreq_bus <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // Strobes are single-cycle; only the FETCH-entering branches raise one.
      rdreq_bus <= '0;
      case (state)
        ST_IDLE: begin
          if (hit) begin
            ch       <= hit_ch;
            rem      <= hit_len;
            checksum <= '0;
            busy     <= 1'b1;
            tx_data  <= SYNC;
            tx_valid <= 1'b1;
            state    <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (xfer) begin
            tx_data  <= ch_byte;
            checksum <= checksum ^ ch_byte;
            state    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (xfer) begin
            tx_data  <= rem;
            checksum <= checksum ^ rem;
            state    <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (xfer) begin
            tx_valid  <= 1'b0;
            rdreq_bus <= strobe(ch);
            state     <= ST_FETCH;
          end
        end
        // FIFO is not show-ahead: the byte appears one cycle after the strobe.
        ST_FETCH: state <= ST_CAPTURE;
        ST_CAPTURE: begin
          tx_data  <= slave_byte;
          checksum <= checksum ^ slave_byte;
          tx_valid <= 1'b1;
          state    <= ST_SEND;
        end
        ST_SEND: begin
          if (xfer) begin
            rem <= rem - 8'd1;
            if (rem == 8'd1) begin
              // checksum already includes the byte just accepted
              tx_data <= checksum;
              state   <= ST_CSUM;
            end else begin
              tx_valid  <= 1'b0;
              rdreq_bus <= strobe(ch);
              state     <= ST_FETCH;
            end
          end
        end
        ST_CSUM: begin
          if (xfer) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            rr_ptr   <= rr_next(ch);
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_packer.sv
// tb_msg_packer: directed scenarios with random payloads and random sink
// back-pressure, checked against packets built from the framing rules.
module tb_msg_packer;

  localparam int N_CH = 5;

  logic                sys_clk = 1'b0;
  logic                n_rst   = 1'b0;
  logic [N_CH-1:0]     have_msg_bus = '0;
  logic [8*N_CH-1:0]   len_bus = '0;
  logic [8*N_CH-1:0]   slave_data_bus;
  logic [N_CH-1:0]     rdreq_bus;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_ready = 1'b1;
  logic                busy;

  msg_packer #(.N_CH(N_CH), .SYNC(8'h55)) dut (
    .sys_clk        (sys_clk),
    .n_rst          (n_rst),
    .have_msg_bus   (have_msg_bus),
    .len_bus        (len_bus),
    .slave_data_bus (slave_data_bus),
    .rdreq_bus      (rdreq_bus),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .busy           (busy)
  );

  initial forever #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] fifo [N_CH][$];
  logic [7:0] out_q[$];
  int         rd_cnt [N_CH];
  int         stall_err = 0;
  int         rq_valid_err = 0;
  int         onehot_err = 0;
  int         cyc = 0;
  int         rq_cyc[$];
  int         rise_cyc[$];
  bit         rand_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sink back-pressure, changed just after each rising edge.
  initial forever begin
    @(posedge sys_clk);
    #1;
    tx_ready = rand_ready ? ($urandom_range(0, 99) >= 40) : 1'b1;
  end

  // Channel FIFOs: a strobe seen in one cycle delivers data in the next.
  initial begin
    logic [N_CH-1:0] rq;
    slave_data_bus = '0;
    forever begin
      @(negedge sys_clk);
      rq = rdreq_bus;
      @(posedge sys_clk);
      #1;
      for (int i = 0; i < N_CH; i++) begin
        if (rq[i]) begin
          rd_cnt[i]++;
          if (fifo[i].size() > 0) slave_data_bus[8*i +: 8] = fifo[i].pop_front();
          else                    slave_data_bus[8*i +: 8] = 8'h00;
        end
      end
    end
  end

  // Stream monitor: collects accepted bytes and protocol violations.
  initial begin
    bit         prev_stall = 1'b0;
    bit         prev_valid = 1'b0;
    logic [7:0] prev_data  = '0;
    forever begin
      @(negedge sys_clk);
      cyc++;
      if (n_rst !== 1'b1) begin
        prev_stall = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) stall_err++;
        if (rdreq_bus != '0 && tx_valid) rq_valid_err++;
        if ($countones(rdreq_bus) > 1) onehot_err++;
        if (rdreq_bus != '0) rq_cyc.push_back(cyc);
        if (tx_valid && !prev_valid) rise_cyc.push_back(cyc);
        if (tx_valid && tx_ready) out_q.push_back(tx_data);
        prev_stall = tx_valid && !tx_ready;
        prev_valid = tx_valid;
        prev_data  = tx_data;
      end
    end
  end

  task automatic step();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic clear_mon();
    out_q.delete();
    rq_cyc.delete();
    rise_cyc.delete();
    for (int i = 0; i < N_CH; i++) rd_cnt[i] = 0;
    stall_err = 0;
    rq_valid_err = 0;
    onehot_err = 0;
  endtask

  // Reference packet: SYNC, address, length, payload, XOR of all but SYNC.
  task automatic add_pkt(input int c, input logic [7:0] d[$], inout logic [7:0] q[$]);
    logic [7:0] x;
    x = 8'(c) ^ 8'(d.size());
    q.push_back(8'h55);
    q.push_back(8'(c));
    q.push_back(8'(d.size()));
    foreach (d[i]) begin
      q.push_back(d[i]);
      x = x ^ d[i];
    end
    q.push_back(x);
  endtask

  task automatic rand_bytes(input int n, output logic [7:0] d[$]);
    d.delete();
    for (int i = 0; i < n; i++) d.push_back(8'($urandom));
  endtask

  task automatic wait_busy(input logic v, input string tag);
    int n = 0;
    while (busy !== v && n < 1000) begin
      step();
      n++;
    end
    check(tag, busy, v);
  endtask

  task automatic set_ch(input int c, input logic h, input logic [7:0] l);
    have_msg_bus[c]   = h;
    len_bus[8*c +: 8] = l;
  endtask

  task automatic send_one(input int c, input logic [7:0] d[$], input string tag);
    foreach (d[i]) fifo[c].push_back(d[i]);
    set_ch(c, 1'b1, 8'(d.size()));
    wait_busy(1'b1, {tag, "_start"});
    set_ch(c, 1'b0, 8'd0);
    wait_busy(1'b0, {tag, "_end"});
    step();
  endtask

  task automatic check_stream(input logic [7:0] exp[$], input string tag);
    check({tag, "_len"}, out_q.size(), exp.size());
    foreach (exp[i]) check($sformatf("%s_b%0d", tag, i), out_q[i], exp[i]);
    out_q.delete();
  endtask

  initial begin
    logic [7:0] d[$];
    logic [7:0] d2[$];
    logic [7:0] d3[$];
    logic [7:0] exp[$];
    int n;

    // Reset state
    repeat (3) step();
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_rdreq", rdreq_bus, 5'h00);
    @(posedge sys_clk);
    #1 n_rst = 1'b1;
    repeat (3) step();
    clear_mon();

    // Test 1: channel 4, fixed payload, sink always ready
    d = '{8'h12, 8'h34, 8'h56};
    send_one(4, d, "t1");
    exp.delete();
    add_pkt(4, d, exp);
    check("t1_csum_const", exp[6], 8'h77);
    check_stream(exp, "t1");
    check("t1_rdreq4", rd_cnt[4], 3);
    check("t1_rdreq_other", rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3], 0);
    check("t1_nrq", rq_cyc.size(), 3);
    for (int k = 0; k < 3; k++)
      check($sformatf("t1_rq_lead%0d", k), rise_cyc[k+1] - rq_cyc[k], 2);
    check("t1_busy_after", busy, 1'b0);
    check("t1_valid_after", tx_valid, 1'b0);
    clear_mon();

    // Test 2: same packet under random back-pressure
    rand_ready = 1'b1;
    send_one(4, d, "t2");
    rand_ready = 1'b0;
    step();
    check_stream(exp, "t2");
    check("t2_stall_hold", stall_err, 0);
    check("t2_rdreq4", rd_cnt[4], 3);
    check("t2_rq_while_valid", rq_valid_err, 0);
    clear_mon();

    // Test 3: channels 0 and 4 together, then channel 0 again after wrap
    rand_bytes(1, d);
    rand_bytes(1, d2);
    rand_bytes(1, d3);
    fifo[0].push_back(d[0]);
    fifo[0].push_back(d3[0]);
    fifo[4].push_back(d2[0]);
    set_ch(0, 1'b1, 8'd1);
    set_ch(4, 1'b1, 8'd1);
    wait_busy(1'b1, "t3_a_start");
    wait_busy(1'b0, "t3_a_end");
    wait_busy(1'b1, "t3_b_start");
    set_ch(4, 1'b0, 8'd0);
    wait_busy(1'b0, "t3_b_end");
    wait_busy(1'b1, "t3_c_start");
    set_ch(0, 1'b0, 8'd0);
    wait_busy(1'b0, "t3_c_end");
    step();
    exp.delete();
    add_pkt(0, d, exp);
    add_pkt(4, d2, exp);
    add_pkt(0, d3, exp);
    check_stream(exp, "t3");
    check("t3_onehot", onehot_err, 0);
    clear_mon();

    // Test 4: channel 2 flags a message with zero length, channel 3 has two
    rand_bytes(2, d);
    set_ch(2, 1'b1, 8'd0);
    foreach (d[i]) fifo[3].push_back(d[i]);
    set_ch(3, 1'b1, 8'd2);
    wait_busy(1'b1, "t4_start");
    set_ch(3, 1'b0, 8'd0);
    wait_busy(1'b0, "t4_end");
    set_ch(2, 1'b0, 8'd0);
    step();
    exp.delete();
    add_pkt(3, d, exp);
    check_stream(exp, "t4");
    check("t4_rdreq2", rd_cnt[2], 0);
    check("t4_rdreq3", rd_cnt[3], 2);
    clear_mon();

    // Test 5: channel 1 inputs change after the length byte
    rand_bytes(9, d);
    foreach (d[i]) fifo[1].push_back(d[i]);
    set_ch(1, 1'b1, 8'd5);
    n = 0;
    while (out_q.size() < 3 && n < 1000) begin
      step();
      n++;
    end
    check("t5_len_seen", out_q.size() >= 3, 1'b1);
    set_ch(1, 1'b0, 8'd9);
    wait_busy(1'b0, "t5_end");
    set_ch(1, 1'b0, 8'd0);
    step();
    d2 = d[0:4];
    exp.delete();
    add_pkt(1, d2, exp);
    check_stream(exp, "t5");
    check("t5_rdreq1", rd_cnt[1], 5);
    fifo[1].delete();
    clear_mon();

    // Test 6: reset in the middle of the second payload byte
    rand_bytes(4, d);
    foreach (d[i]) fifo[0].push_back(d[i]);
    set_ch(0, 1'b1, 8'd4);
    n = 0;
    while (out_q.size() < 4 && n < 1000) begin
      step();
      n++;
    end
    check("t6_p0_seen", out_q.size(), 4);
    step();
    n_rst = 1'b0;
    #1;
    check("t6_rst_valid", tx_valid, 1'b0);
    check("t6_rst_data", tx_data, 8'h00);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_rdreq", rdreq_bus, 5'h00);
    set_ch(0, 1'b0, 8'd0);
    repeat (3) step();
    fifo[0].delete();
    @(posedge sys_clk);
    #1 n_rst = 1'b1;
    clear_mon();
    repeat (20) step();
    check("t6_idle_out", out_q.size(), 0);
    check("t6_idle_busy", busy, 1'b0);
    check("t6_idle_rdreq", rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3] + rd_cnt[4], 0);
    rand_bytes(2, d);
    send_one(0, d, "t6_fresh");
    exp.delete();
    add_pkt(0, d, exp);
    check_stream(exp, "t6_fresh");
    check("t6_fresh_rdreq0", rd_cnt[0], 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/msg_packer.md
# msg_packer

Downstream stage of the functional-test block and its sibling channel blocks. It arbitrates round-robin among up to N_CH slave channels that signal pending messages. It drains the selected channel's output FIFO byte by byte through that channel's read strobe. Each message goes out as a framed packet (sync, address, length, payload, XOR checksum) on a valid/ready byte stream toward the PC-side transmitter.

## Interface
Parameters:
- N_CH, 5, number of slave channels (channel index width = $clog2(N_CH))
- SYNC, 8'h55, packet start byte

Ports:
- sys_clk  in  1  single clock for all logic
- n_rst  in  1  asynchronous, active-low reset
- have_msg_bus  in  N_CH  bit i = channel i has data pending
- len_bus  in  8*N_CH  bits [8i+7:8i] = channel i available byte count, 0..255
- slave_data_bus  in  8*N_CH  bits [8i+7:8i] = channel i FIFO output; not show-ahead, valid the cycle after its rdreq
- rdreq_bus  out  N_CH  one-cycle read strobe per channel
- tx_data  out  8  stream byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts; transfer occurs on a cycle with tx_valid & tx_ready
- busy  out  1  high from packet selection until checksum accepted

## Operation
- Reset values: rdreq_bus=0, tx_data=0, tx_valid=0, busy=0, rr_ptr=0, state=IDLE, checksum=0.
- States: IDLE, SYNC, ADDR, LEN, FETCH, CAPTURE, SEND, CSUM.
- IDLE: search channels rr_ptr, rr_ptr+1, … (mod N_CH) for the first i with have_msg_bus[i]=1 and len≠0.
  - On a hit, latch ch=i and rem=len_i, clear checksum, set busy, and go to SYNC.
  - A channel with have_msg=1 and len=0 is skipped.
- SYNC: tx_data=SYNC, tx_valid=1. Go to ADDR on transfer.
- ADDR: tx_data=zero-extended ch. Checksum ^= byte. Go to LEN on transfer.
- LEN: tx_data=latched rem. Checksum ^= byte. Go to FETCH on transfer.
- FETCH: tx_valid=0 and rdreq_bus[ch]=1 for exactly this cycle. Go to CAPTURE.
- CAPTURE: register slave_data_bus[8ch+:8] into tx_data. Checksum ^= byte. Go to SEND.
- SEND: tx_valid=1. On transfer, rem=rem-1; go to CSUM if the new rem=0, else FETCH.
- CSUM: tx_data=checksum, i.e. XOR of ADDR, LEN and all payload bytes (SYNC excluded). On transfer: tx_valid=0, busy=0, rr_ptr=(ch+1) mod N_CH, go to IDLE.
- Length is sampled only in IDLE. Changes of have_msg/len during a packet are ignored, and the packet always carries exactly the latched count.
- While tx_valid=1 and tx_ready=0, tx_data and state are held. tx_valid never drops before a transfer.
- Only rdreq_bus[ch] may pulse, only in FETCH, and once per payload byte. All other rdreq bits stay 0.
- Asynchronous reset mid-packet returns to reset values immediately. The partial packet is abandoned and no further rdreq is issued.

## Timing
- With tx_ready=1 constantly: selection cycle t0 (IDLE), SYNC on t1, ADDR t2, LEN t3, FETCH t4, CAPTURE t5, first payload byte valid t6.
- Each payload byte takes 3 cycles (FETCH, CAPTURE, SEND). The checksum is valid the cycle after the last payload transfer.
- Packet with L payload bytes: 3+3L+1 active cycles plus one IDLE cycle before the next selection.
- All outputs are registered. There is no combinational path from tx_ready to tx_valid/tx_data or to rdreq_bus.

## Test plan
- Channel 4, len=3, FIFO bytes 12,34,56, tx_ready=1. Stream must be 55 04 03 12 34 56 77. Exactly 3 rdreq_bus[4] pulses, each 2 cycles before its byte's tx_valid cycle. busy clears after 77.
- Same stimulus with tx_ready driven pseudo-randomly (about 40% low). Byte sequence must be identical and tx_data stable during every stall. Still exactly 3 rdreq pulses, none issued while a byte awaits transfer.
- Channels 0 and 4 pending simultaneously, len=1 each, rr_ptr=0. The ch0 packet is sent first, then ch4. With ch0 still pending afterwards, it is next (wrap-around).
- Channel 2: have_msg=1, len=0; channel 3: len=2. Only the ch3 packet (55 03 02 d0 d1 csum) is emitted, and rdreq_bus[2] never pulses.
- Channel 1, len=5; deassert have_msg_bus[1] and change len_1 to 9 after the LEN byte. Exactly 5 payload bytes plus the checksum must still be sent.
- Assert n_rst low during the 2nd payload byte. All outputs go to 0 immediately. After release with nothing pending, the stream stays idle. With ch0 pending, the next packet is a fresh ch0 packet.
